// File: rtl/store_pkg.sv
// store_pkg: shared constants, state encoding and helpers for the store
// serializer.
//   SZ_BYTE / SZ_HALF / SZ_WORD : req_size encodings (3 is reserved)
//   state_t                     : serializer FSM states
//   byte_count(size)            : number of bytes written for a store size
//   store_fault(size, lo)       : reserved size or natural-alignment violation
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  function automatic logic store_fault(input logic [1:0] size,
                                       input logic [1:0] addr_lo);
    logic f;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = addr_lo[0];
      SZ_WORD: f = |addr_lo;
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/store_lane_sel.sv
// store_lane_sel: picks the byte of a store value that goes out at byte
// index k, big-endian (most significant byte of the stored item first).
//   data : 32-bit source register value
//   size : store size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   k    : byte index within the transfer
//   lane : selected byte
module store_lane_sel
  import store_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  k,
  output logic [7:0]  lane
);

  always_comb begin
    lane = data[7:0];
    case (size)
      SZ_WORD: begin
        case (k)
          2'd0:    lane = data[31:24];
          2'd1:    lane = data[23:16];
          2'd2:    lane = data[15:8];
          default: lane = data[7:0];
        endcase
      end
      SZ_HALF: lane = k[0] ? data[7:0] : data[15:8];
      default: lane = data[7:0];
    endcase
  end

endmodule

// File: rtl/store_serializer.sv
// store_serializer: narrows a 32-bit register value to a byte/half/word
// store, checks natural alignment and serializes it as big-endian byte
// writes onto an 8-bit memory port with a per-byte acknowledge.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_addr/data/size    : store address, source value, size
//   mem_we/addr/wdata     : byte write port (held stable until mem_ack)
//   mem_ack               : memory accepted the current byte
//   done                  : one-cycle completion pulse
//   misaligned            : with done, request faulted and nothing was written
module store_serializer
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              misaligned
);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic [2:0]        n_q;
  logic [1:0]        k;
  logic              fault;

  logic              accept;
  logic              last;
  logic [7:0]        lane;

  // FINISH accepts a new request just like IDLE, giving one bubble per store.
  assign accept = req_valid && (state != ST_WRITE);
  assign last   = ({1'b0, k} == (n_q - 3'd1));

  store_lane_sel u_lane (
    .data (data_q),
    .size (size_q),
    .k    (k),
    .lane (lane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      base   <= '0;
      data_q <= '0;
      size_q <= '0;
      n_q    <= 3'd1;
      k      <= '0;
      fault  <= 1'b0;
    end else begin
      case (state)
        ST_WRITE: begin
          if (mem_ack) begin
            if (last) begin
              state <= ST_FINISH;
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        default: begin
          if (accept) begin
            base   <= req_addr;
            data_q <= req_data;
            size_q <= req_size;
            n_q    <= byte_count(req_size);
            k      <= '0;
            if (store_fault(req_size, req_addr[1:0])) begin
              fault <= 1'b1;
              state <= ST_FINISH;
            end else begin
              fault <= 1'b0;
              state <= ST_WRITE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Outputs decode only state and latched registers; the write port reads
  // zero outside WRITE so idle values match the reset values.
  assign req_ready  = (state != ST_WRITE);
  assign mem_we     = (state == ST_WRITE);
  assign mem_addr   = mem_we ? (base + ADDR_W'(k)) : '0;
  assign mem_wdata  = mem_we ? lane : '0;
  assign done       = (state == ST_FINISH);
  assign misaligned = (state == ST_FINISH) && fault;

endmodule
